// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full adder (two half adders + carry flop) stepped LSB-first
// across WIDTH bits. Define SERIAL_ADD_SUB_EN to add the in_sub port and a-b support.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sub_cur;
  logic               sub_acc;
  logic               last_bit;
  logic               b_bit;
  logic [1:0]         ha0;
  logic [1:0]         ha1;
  logic               s_bit;
  logic               c_nxt;

  // Returns {carry, sum} of a single half adder.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q, sub_d;

  assign sub_cur = sub_q;
  assign sub_acc = in_sub;

  always_ff @(posedge clk) begin
    sub_q <= sub_d;
  end

  always_comb begin
    sub_d = sub_q;
    if (state_q == IDLE && in_valid) begin
      sub_d = in_sub;
    end
  end
`else
  assign sub_cur = 1'b0;
  assign sub_acc = 1'b0;
`endif

  // Shared bit-slice: subtract inverts B on the fly, carry preset supplies the +1.
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  assign b_bit    = b_q[0] ^ sub_cur;
  assign ha0      = half_add(a_q[0], b_bit);
  assign ha1      = half_add(ha0[0], carry_q);
  assign s_bit    = ha1[0];
  assign c_nxt    = ha0[1] | ha1[1];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = SHIFT;
      SHIFT:   if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Visible result, carry and counter are cleared by reset so no partial result survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          carry_d = sub_acc;
        end
      end
      SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {s_bit, sum_q[WIDTH-1:1]};
        carry_d = c_nxt;
        if (last_bit) begin
          cout_d = c_nxt;
          cnt_d  = '0;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    sum       = sum_q;
    cout      = cout_q;
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8) with a result scoreboard.
// Compile with +define+SERIAL_ADD_SUB_EN to also exercise subtraction.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W:0] sb_q[$];

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
`ifdef SERIAL_ADD_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [W:0] r;
    if (s) r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else   r = {1'b0, x} + {1'b0, y};
    return r;
  endfunction

  // Inputs change at posedge+1, so at negedge a visible handshake will complete on the next edge.
  always @(negedge clk) begin
    logic       sub_eff;
    logic [W:0] e;
`ifdef SERIAL_ADD_SUB_EN
    sub_eff = in_sub;
`else
    sub_eff = 1'b0;
`endif
    if (rst) begin
      sb_q.delete();
    end else begin
      if (in_valid && in_ready) sb_q.push_back(model(a_i, b_i, sub_eff));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected_result", 64'(out_valid), 64'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("sb_sum", 64'(sum), 64'(e[W-1:0]));
          check_eq("sb_cout", 64'(cout), 64'(e[W]));
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    bit done = 0;
    @(posedge clk); #1;
    a_i = x; b_i = y; in_sub = s; in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        done = 1;
      end
    end
    if (!done) begin
      check_eq("send_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (out_valid) return;
    end
    check_eq("out_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                        input logic [W-1:0] es, input logic ec);
    int n;
    out_ready = 1'b1;
    send(x, y, s);
    wait_out_valid(n);
    check_eq("latency", 64'(n), 64'(W + 1));
    check_eq("sum_const", 64'(sum), 64'(es));
    check_eq("cout_const", 64'(cout), 64'(ec));
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("in_ready_after", 64'(in_ready), 64'd1);
    check_eq("out_valid_drop", 64'(out_valid), 64'd0);
  endtask

  initial begin
    int n;
    int ov_cnt;
    logic [W-1:0] s0;
    logic         c0;
    logic [W-1:0] ra, rb;
    logic [W:0]   rr;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_i = '0; b_i = '0; in_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_sum", 64'(sum), 64'd0);
    check_eq("rst_cout", 64'(cout), 64'd0);

    run_op(8'h3C, 8'h55, 1'b0, 8'h91, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

    // Backpressure with a competing operand that must wait in IDLE
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b0);
    wait_out_valid(n);
    s0 = sum; c0 = cout;
    check_eq("bp_sum_const", 64'(s0), 64'h46);
    @(posedge clk); #1;
    a_i = 8'h77; b_i = 8'h11; in_sub = 1'b0; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_eq("bp_out_valid", 64'(out_valid), 64'd1);
      check_eq("bp_in_ready", 64'(in_ready), 64'd0);
      check_eq("bp_sum_stable", 64'(sum), 64'(s0));
      check_eq("bp_cout_stable", 64'(cout), 64'(c0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    begin
      bit acc = 0;
      for (int i = 0; i < 20 && !acc; i++) begin
        @(negedge clk);
        if (in_ready) begin
          @(posedge clk); #1;
          in_valid = 1'b0;
          acc = 1;
        end
      end
      if (!acc) begin
        check_eq("bp_accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
      end
    end
    wait_out_valid(n);
    check_eq("bp_next_sum", 64'(sum), 64'h88);
    check_eq("bp_next_cout", 64'(cout), 64'd0);
    @(posedge clk); #1;

    // Reset during the 4th SHIFT cycle
    send(8'h0F, 8'h0F, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_sum", 64'(sum), 64'd0);
    check_eq("mid_rst_cout", 64'(cout), 64'd0);
    ov_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) ov_cnt++;
    end
    check_eq("mid_rst_no_pulse", 64'(ov_cnt), 64'd0);
    run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h0A, 8'h03, 1'b1, 8'h07, 1'b1);
    run_op(8'h03, 8'h0A, 1'b1, 8'hF9, 1'b0);
    run_op(8'h55, 8'h55, 1'b1, 8'h00, 1'b1);
`endif

    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rr = {1'b0, ra} + {1'b0, rb};
      run_op(ra, rb, 1'b0, rr[W-1:0], rr[W]);
    end

    repeat (3) @(negedge clk);
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
